// File: rtl/screen_draw_sequencer.sv
// Arbitrates draw requests onto one VGA plot port and streams the granted screen
// from the screen ROM, one pixel per clock, in raster order.
module screen_draw_sequencer #(
  parameter int NREQ     = 10,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ROM_LAT  = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [18:0]     rom_addr,
  input  logic [2:0]      rom_data,
  output logic [7:0]      vga_x,
  output logic [6:0]      vga_y,
  output logic [2:0]      vga_colour,
  output logic            vga_plot,
  output logic [2:0]      state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SCAN    = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  // Handshake: req[i] is a level held by the requester until it sees the one-cycle
  // done[i]; the grant lasts until req[id] falls, and a fall before done aborts the draw.
  logic [3:0]      id_q;
  logic [3:0]      pick;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [14:0]     pix_q;
  logic            req_id;
  logic            issue;
  logic            abort;
  logic            drain_done;
  logic [NREQ-1:0] id_onehot;

  logic [ROM_LAT:0] pipe_v;
  logic [7:0]       pipe_x [ROM_LAT+1];
  logic [6:0]       pipe_y [ROM_LAT+1];

  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) pick = 4'(i);
    end
  end

  assign req_id     = req[id_q];
  assign issue      = (state == ST_SCAN) && req_id;
  assign abort      = ((state == ST_SCAN) || (state == ST_DRAIN)) && !req_id;
  // Drain ends once the last issued pixel is the only one left and is on the plot port.
  assign drain_done = pipe_v[ROM_LAT] && !(|pipe_v[ROM_LAT-1:0]);
  assign id_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << id_q;

  assign done       = (state == ST_DONE) ? id_onehot : '0;
  assign busy       = (state != ST_IDLE);
  assign vga_plot   = pipe_v[ROM_LAT];
  assign vga_x      = pipe_x[ROM_LAT];
  assign vga_y      = pipe_y[ROM_LAT];
  assign vga_colour = vga_plot ? rom_data : 3'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= '0;
      rom_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            id_q  <= pick;
            x_q   <= '0;
            y_q   <= '0;
            pix_q <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!req_id) begin
            state <= ST_IDLE;
          end else begin
            rom_addr <= {id_q, pix_q};
            if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
              state <= ST_DRAIN;
            end else if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + 7'd1;
            end else begin
              x_q <= x_q + 8'd1;
            end
            pix_q <= pix_q + 15'd1;
          end
        end
        ST_DRAIN: begin
          if (!req_id)         state <= ST_IDLE;
          else if (drain_done) state <= ST_DONE;
        end
        ST_DONE:    state <= ST_RELEASE;
        ST_RELEASE: if (!req_id) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Coordinates travel alongside the ROM read so they meet rom_data at the plot port.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
      end
    end else begin
      pipe_v[0] <= issue;
      pipe_x[0] <= x_q;
      pipe_y[0] <= y_q;
      for (int i = 1; i <= ROM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1] & ~abort;
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
      end
    end
  end

endmodule

// File: tb/tb_screen_draw_sequencer.sv
// Directed bench for screen_draw_sequencer: one instance with ROM latency 1 and one
// with ROM latency 3, each fed by a ROM model returning the low address bits.
module tb_screen_draw_sequencer;

  localparam int SW = 160;
  localparam int SH = 120;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [9:0]  req1 = '0, req3 = '0;
  logic [9:0]  done1, done3;
  logic        busy1, busy3;
  logic [18:0] rom_addr1, rom_addr3;
  logic [2:0]  rom_data1, rom_data3;
  logic [7:0]  vx1, vx3;
  logic [6:0]  vy1, vy3;
  logic [2:0]  vc1, vc3;
  logic        vp1, vp3;
  logic [2:0]  st1, st3;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  bit mon1 = 0, mon3 = 0;
  int cnt1 = 0, cnt3 = 0, stray1 = 0, stray3 = 0;
  int first1 = 0, first3 = 0;
  logic [14:0] first_xy1 = '0, last_xy1 = '0;
  logic [9:0]  done_acc1 = '0, done_acc3 = '0;

  int k;

  always #5 clock = ~clock;

  screen_draw_sequencer #(.ROM_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .req(req1), .done(done1), .busy(busy1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .vga_x(vx1), .vga_y(vy1),
    .vga_colour(vc1), .vga_plot(vp1), .state(st1)
  );

  screen_draw_sequencer #(.ROM_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .req(req3), .done(done3), .busy(busy3),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .vga_x(vx3), .vga_y(vy3),
    .vga_colour(vc3), .vga_plot(vp3), .state(st3)
  );

  // Screen ROM models: colour = low three address bits, returned after the set latency.
  logic [18:0] a1_q;
  logic [18:0] a3_q [3];
  always @(posedge clock) begin
    a1_q    <= rom_addr1;
    a3_q[0] <= rom_addr3;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign rom_data1 = a1_q[2:0];
  assign rom_data3 = a3_q[2][2:0];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] raster(input int n);
    return 32'({7'(n / SW), 8'(n % SW), 3'(n % 8)});
  endfunction

  // One clock: advance, sample 1ns after the edge, run the plot scoreboards.
  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
    done_acc1 |= done1;
    done_acc3 |= done3;
    if (vp1) begin
      if (mon1) begin
        if (cnt1 == 0) begin
          first1    = cycle;
          first_xy1 = {vy1, vx1};
        end
        check("raster1", 32'({vy1, vx1, vc1}), raster(cnt1));
        last_xy1 = {vy1, vx1};
        cnt1++;
      end else stray1++;
    end
    if (vp3) begin
      if (mon3) begin
        if (cnt3 == 0) first3 = cycle;
        check("raster3", 32'({vy3, vx3, vc3}), raster(cnt3));
        cnt3++;
      end else stray3++;
    end
  endtask

  task automatic start_mon1();
    cnt1 = 0; stray1 = 0; mon1 = 1; done_acc1 = '0;
  endtask

  task automatic wait_done1(input int budget);
    for (int n = 0; n < budget && done1 == '0; n++) tick();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick(); tick();
    check("rst_done", 32'(done1), 32'h0);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_plot", 32'(vp1), 32'h0);
    check("rst_addr", 32'(rom_addr1), 32'h0);
    check("rst_xy", 32'({vy1, vx1}), 32'h0);
    check("rst_colour", 32'(vc1), 32'h0);
    check("rst_state", 32'(st1), 32'h0);
    reset = 1'b0;
    tick();

    // 1: single request, full screen
    start_mon1();
    req1 = 10'b1;
    k = cycle + 1;
    wait_done1(19300);
    check("t1_first_lat", 32'(first1 - k), 32'd2);
    check("t1_first_xy", 32'(first_xy1), 32'h0);
    check("t1_done_lat", 32'(cycle - k), 32'd19202);
    check("t1_done_val", 32'(done1), 32'h001);
    check("t1_plots", 32'(cnt1), 32'd19200);
    check("t1_last_xy", 32'(last_xy1), 32'({7'd119, 8'd159}));
    check("t1_busy_done", 32'(busy1), 32'h1);
    tick();
    check("t1_done_pulse", 32'(done1), 32'h0);
    check("t1_busy_rel", 32'(busy1), 32'h1);
    req1 = '0;
    tick();
    check("t1_busy_idle", 32'(busy1), 32'h0);
    check("t1_state_idle", 32'(st1), 32'h0);

    // 2: simultaneous requests 2 and 9, lowest index served first
    start_mon1();
    req1 = 10'b10_0000_0100;
    repeat (5) tick();
    check("t2_id2", 32'(rom_addr1[18:15]), 32'd2);
    wait_done1(19300);
    check("t2_done_val", 32'(done1), 32'h004);
    check("t2_plots", 32'(cnt1), 32'd19200);
    tick(); tick();
    check("t2_release", 32'(st1), 32'd4);
    check("t2_busy_rel", 32'(busy1), 32'h1);
    cnt1 = 0;
    req1 = 10'b10_0000_0000;
    k = cycle + 2;
    for (int n = 0; n < 10 && cnt1 == 0; n++) tick();
    check("t2_first9_lat", 32'(first1 - k), 32'd2);
    check("t2_first9_xy", 32'(first_xy1), 32'h0);
    check("t2_id9", 32'(rom_addr1[18:15]), 32'd9);
    repeat (30) tick();
    req1 = '0;
    mon1 = 0;
    repeat (5) tick();
    check("t2_done_acc", 32'(done_acc1), 32'h004);
    check("t2_state_idle", 32'(st1), 32'h0);

    // 3: request held long after done -> no retrigger
    start_mon1();
    req1 = 10'b00_0000_1000;
    wait_done1(19300);
    check("t3_done_val", 32'(done1), 32'h008);
    mon1 = 0;
    stray1 = 0;
    repeat (50) tick();
    check("t3_no_plot", 32'(stray1), 32'h0);
    check("t3_busy", 32'(busy1), 32'h1);
    check("t3_release", 32'(st1), 32'd4);
    check("t3_done_once", 32'(done_acc1), 32'h008);
    req1 = '0;
    tick();
    check("t3_idle", 32'(st1), 32'h0);
    check("t3_busy_low", 32'(busy1), 32'h0);

    // 4: abort at pixel 1000
    start_mon1();
    req1 = 10'b00_0010_0000;
    for (int n = 0; n < 1100 && cnt1 < 1000; n++) tick();
    check("t4_reached", 32'(cnt1), 32'd1000);
    req1 = '0;
    mon1 = 0;
    stray1 = 0;
    tick();
    check("t4_stop_fast", 32'(stray1 <= 1), 32'h1);
    stray1 = 0;
    repeat (20) tick();
    check("t4_no_plot", 32'(stray1), 32'h0);
    check("t4_no_done", 32'(done_acc1), 32'h0);
    check("t4_idle", 32'(st1), 32'h0);
    check("t4_busy", 32'(busy1), 32'h0);

    // 5: reset mid-scan, then restart from (0,0)
    start_mon1();
    req1 = 10'b1;
    for (int n = 0; n < 600 && cnt1 < 500; n++) tick();
    check("t5_reached", 32'(cnt1), 32'd500);
    reset = 1'b1;
    mon1 = 0;
    tick();
    check("t5_done", 32'(done1), 32'h0);
    check("t5_busy", 32'(busy1), 32'h0);
    check("t5_plot", 32'(vp1), 32'h0);
    check("t5_addr", 32'(rom_addr1), 32'h0);
    check("t5_xy", 32'({vy1, vx1}), 32'h0);
    check("t5_colour", 32'(vc1), 32'h0);
    check("t5_state", 32'(st1), 32'h0);
    reset = 1'b0;
    start_mon1();
    k = cycle + 1;
    for (int n = 0; n < 20 && cnt1 == 0; n++) tick();
    check("t5_restart_lat", 32'(first1 - k), 32'd2);
    check("t5_restart_xy", 32'(first_xy1), 32'h0);
    repeat (10) tick();
    req1 = '0;
    mon1 = 0;
    repeat (3) tick();
    check("t5_no_done", 32'(done_acc1), 32'h0);

    // 6: ROM latency 3, colour alignment
    cnt3 = 0; stray3 = 0; mon3 = 1; done_acc3 = '0;
    req3 = 10'b00_1000_0000;
    k = cycle + 1;
    for (int n = 0; n < 2100 && cnt3 < 2000; n++) tick();
    check("t6_reached", 32'(cnt3), 32'd2000);
    check("t6_first_lat", 32'(first3 - k), 32'd4);
    check("t6_id7", 32'(rom_addr3[18:15]), 32'd7);
    req3 = '0;
    mon3 = 0;
    repeat (3) tick();
    stray3 = 0;
    repeat (10) tick();
    check("t6_no_plot", 32'(stray3), 32'h0);
    check("t6_no_done", 32'(done_acc3), 32'h0);
    check("t6_idle", 32'(st3), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
